// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, register IDs and status codes.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RRSP    = 4'h4;
   localparam logic [3:0] RNONE   = 4'hF;

   typedef enum logic [3:0] {
      SBUB = 4'h0,
      SAOK = 4'h1,
      SHLT = 4'h2,
      SADR = 4'h3,
      SINS = 4'h4
   } stat_e;

endpackage

// File: rtl/regfile15.sv
// Fifteen-entry register file: two synchronous write ports (M port wins a
// same-register conflict) and two combinational read ports, ID F reads as 0.
module regfile15
   import y86_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             we_e,
   input  logic [3:0]       addr_e,
   input  logic [WIDTH-1:0] data_e,
   input  logic             we_m,
   input  logic [3:0]       addr_m,
   input  logic [WIDTH-1:0] data_m,
   input  logic [3:0]       raddr_a,
   input  logic [3:0]       raddr_b,
   output logic [WIDTH-1:0] rdata_a,
   output logic [WIDTH-1:0] rdata_b
);

   logic [WIDTH-1:0] regs_q [15];
   logic [WIDTH-1:0] regs_d [15];

   // The M write is applied after the E write so it overrides on a shared ID.
   always_comb begin
      for (int i = 0; i < 15; i++) begin
         regs_d[i] = regs_q[i];
         if (we_e && addr_e == 4'(i)) regs_d[i] = data_e;
         if (we_m && addr_m == 4'(i)) regs_d[i] = data_m;
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < 15; i++) begin
         if (reset) regs_q[i] <= '0;
         else       regs_q[i] <= regs_d[i];
      end
   end

   always_comb begin
      rdata_a = '0;
      rdata_b = '0;
      for (int i = 0; i < 15; i++) begin
         if (raddr_a == 4'(i)) rdata_a = regs_q[i];
         if (raddr_b == 4'(i)) rdata_b = regs_q[i];
      end
   end

endmodule

// File: rtl/regfile_wb.sv
// Y86 writeback stage: W pipeline register, register-file commit, decode
// read ports with optional W-stage bypass, and sticky halt/status tracking.
module regfile_wb
   import y86_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter bit BYPASS = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             W_stall,
   input  logic             W_bubble,
   input  logic [3:0]       m_stat,
   input  logic [3:0]       m_icode,
   input  logic [WIDTH-1:0] m_valE,
   input  logic [WIDTH-1:0] m_valM,
   input  logic [3:0]       m_dstE,
   input  logic [3:0]       m_dstM,
   input  logic [3:0]       srcA,
   input  logic [3:0]       srcB,
   output logic [WIDTH-1:0] valA,
   output logic [WIDTH-1:0] valB,
   output logic [3:0]       W_icode,
   output logic [3:0]       W_dstE,
   output logic [3:0]       W_dstM,
   output logic [WIDTH-1:0] W_valE,
   output logic [WIDTH-1:0] W_valM,
   output logic [3:0]       prog_stat,
   output logic             halted
);

   stat_e            stat_q, stat_d;
   logic [3:0]       icode_q, icode_d;
   logic [3:0]       dst_e_q, dst_e_d;
   logic [3:0]       dst_m_q, dst_m_d;
   logic [WIDTH-1:0] val_e_q, val_e_d;
   logic [WIDTH-1:0] val_m_q, val_m_d;
   logic             halted_q, halted_d;
   stat_e            prog_stat_q, prog_stat_d;
   logic             commit_en;
   logic [WIDTH-1:0] rf_a, rf_b;

   always_comb begin
      stat_d  = stat_q;
      icode_d = icode_q;
      dst_e_d = dst_e_q;
      dst_m_d = dst_m_q;
      val_e_d = val_e_q;
      val_m_d = val_m_q;
      if (W_bubble) begin
         stat_d  = SAOK;
         icode_d = INOP;
         dst_e_d = RNONE;
         dst_m_d = RNONE;
         val_e_d = '0;
         val_m_d = '0;
      end else if (!W_stall) begin
         stat_d  = stat_e'(m_stat);
         icode_d = m_icode;
         dst_e_d = m_dstE;
         dst_m_d = m_dstM;
         val_e_d = m_valE;
         val_m_d = m_valM;
      end
   end

   // Only the first faulting status is latched; everything after it is frozen.
   always_comb begin
      halted_d    = halted_q;
      prog_stat_d = prog_stat_q;
      if (!halted_q && (stat_q == SHLT || stat_q == SADR || stat_q == SINS)) begin
         halted_d    = 1'b1;
         prog_stat_d = stat_q;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_q      <= SAOK;
         icode_q     <= INOP;
         dst_e_q     <= RNONE;
         dst_m_q     <= RNONE;
         val_e_q     <= '0;
         val_m_q     <= '0;
         halted_q    <= 1'b0;
         prog_stat_q <= SAOK;
      end else begin
         stat_q      <= stat_d;
         icode_q     <= icode_d;
         dst_e_q     <= dst_e_d;
         dst_m_q     <= dst_m_d;
         val_e_q     <= val_e_d;
         val_m_q     <= val_m_d;
         halted_q    <= halted_d;
         prog_stat_q <= prog_stat_d;
      end
   end

   assign commit_en = !halted_q && (stat_q == SAOK);

   regfile15 #(.WIDTH(WIDTH)) u_regs (
      .clock   (clock),
      .reset   (reset),
      .we_e    (commit_en && dst_e_q != RNONE),
      .addr_e  (dst_e_q),
      .data_e  (val_e_q),
      .we_m    (commit_en && dst_m_q != RNONE),
      .addr_m  (dst_m_q),
      .data_m  (val_m_q),
      .raddr_a (srcA),
      .raddr_b (srcB),
      .rdata_a (rf_a),
      .rdata_b (rf_b)
   );

   // Bypass order mirrors commit order: the M value is what will be stored.
   always_comb begin
      valA = rf_a;
      valB = rf_b;
      if (BYPASS && commit_en) begin
         if (srcA != RNONE && srcA == dst_m_q)      valA = val_m_q;
         else if (srcA != RNONE && srcA == dst_e_q) valA = val_e_q;
         if (srcB != RNONE && srcB == dst_m_q)      valB = val_m_q;
         else if (srcB != RNONE && srcB == dst_e_q) valB = val_e_q;
      end
   end

   assign W_icode   = icode_q;
   assign W_dstE    = dst_e_q;
   assign W_dstM    = dst_m_q;
   assign W_valE    = val_e_q;
   assign W_valM    = val_m_q;
   assign prog_stat = prog_stat_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypassing and non-bypassing instances share
// stimulus; vectors carry hand-computed read results.
module tb_regfile_wb;
   import y86_pkg::*;

   logic        clock = 1'b0;
   logic        reset, w_stall, w_bubble;
   logic [3:0]  m_stat, m_icode, m_dst_e, m_dst_m, src_a, src_b;
   logic [63:0] m_val_e, m_val_m;
   logic [63:0] val_a, val_b, w_val_e, w_val_m;
   logic [3:0]  w_icode, w_dst_e, w_dst_m, prog_stat;
   logic        halted;
   logic [63:0] nb_val_a, nb_val_b, nb_w_val_e, nb_w_val_m;
   logic [3:0]  nb_w_icode, nb_w_dst_e, nb_w_dst_m, nb_prog_stat;
   logic        nb_halted;
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic [3:0]  icode;
      logic [3:0]  dst_e;
      logic [3:0]  dst_m;
      logic [63:0] val_e;
      logic [63:0] val_m;
      logic [3:0]  src_a;
      logic [3:0]  src_b;
      logic [63:0] exp_byp_a;
      logic [63:0] exp_nb_a;
      logic [63:0] exp_a;
      logic [63:0] exp_b;
   } vec_t;

   vec_t        vecs [6];
   logic [63:0] sweep_exp [15];

   always #5 clock = ~clock;

   regfile_wb #(.WIDTH(64), .BYPASS(1'b1)) dut (
      .clock(clock), .reset(reset), .W_stall(w_stall), .W_bubble(w_bubble),
      .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_val_e), .m_valM(m_val_m),
      .m_dstE(m_dst_e), .m_dstM(m_dst_m), .srcA(src_a), .srcB(src_b),
      .valA(val_a), .valB(val_b), .W_icode(w_icode), .W_dstE(w_dst_e),
      .W_dstM(w_dst_m), .W_valE(w_val_e), .W_valM(w_val_m),
      .prog_stat(prog_stat), .halted(halted)
   );

   regfile_wb #(.WIDTH(64), .BYPASS(1'b0)) dut_nb (
      .clock(clock), .reset(reset), .W_stall(w_stall), .W_bubble(w_bubble),
      .m_stat(m_stat), .m_icode(m_icode), .m_valE(m_val_e), .m_valM(m_val_m),
      .m_dstE(m_dst_e), .m_dstM(m_dst_m), .srcA(src_a), .srcB(src_b),
      .valA(nb_val_a), .valB(nb_val_b), .W_icode(nb_w_icode), .W_dstE(nb_w_dst_e),
      .W_dstM(nb_w_dst_m), .W_valE(nb_w_val_e), .W_valM(nb_w_val_m),
      .prog_stat(nb_prog_stat), .halted(nb_halted)
   );

   task automatic step_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic [3:0] stat, input logic [3:0] icode,
                                input logic [3:0] dst_e, input logic [3:0] dst_m,
                                input logic [63:0] ve, input logic [63:0] vm);
      m_stat  = stat;
      m_icode = icode;
      m_dst_e = dst_e;
      m_dst_m = dst_m;
      m_val_e = ve;
      m_val_m = vm;
   endtask

   task automatic apply_nop();
      applyStimulus(4'h1, INOP, RNONE, RNONE, 64'h0, 64'h0);
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic read_ports(input logic [3:0] a, input logic [3:0] b);
      src_a = a;
      src_b = b;
      #1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0] = '{4'h6, 4'h2, 4'hF, 64'h2A382812, 64'h0, 4'h2, 4'h3,
                  64'h2A382812, 64'h0, 64'h2A382812, 64'h0};
      vecs[1] = '{4'hB, 4'h4, 4'h4, 64'h100, 64'h55, 4'h4, 4'h2,
                  64'h55, 64'h0, 64'h55, 64'h2A382812};
      vecs[2] = '{4'hB, 4'h4, 4'h7, 64'h100, 64'h55, 4'h4, 4'h7,
                  64'h100, 64'h55, 64'h100, 64'h55};
      vecs[3] = '{4'h3, 4'hF, 4'hF, 64'hFFFF, 64'h0, 4'hF, 4'hF,
                  64'h0, 64'h0, 64'h0, 64'h0};
      vecs[4] = '{4'h3, 4'hE, 4'hF, 64'hDEADBEEF01234567, 64'h0, 4'hE, 4'h0,
                  64'hDEADBEEF01234567, 64'h0, 64'hDEADBEEF01234567, 64'h0};
      vecs[5] = '{4'h5, 4'hF, 4'h1, 64'h0, 64'h8000000000000001, 4'h1, 4'h4,
                  64'h8000000000000001, 64'h0, 64'h8000000000000001, 64'h100};
      for (int i = 0; i < 15; i++) sweep_exp[i] = 64'h0;
      sweep_exp[1]  = 64'h8000000000000001;
      sweep_exp[2]  = 64'h2A382812;
      sweep_exp[4]  = 64'h100;
      sweep_exp[7]  = 64'h55;
      sweep_exp[14] = 64'hDEADBEEF01234567;

      reset = 1'b1; w_stall = 1'b0; w_bubble = 1'b0;
      apply_nop();
      read_ports(4'h0, 4'h0);
      step_cycle();
      reset = 1'b0;

      // Reset defaults on both instances and an all-zero register sweep.
      checkOutput("rst_icode", 64'(w_icode), 64'h1);
      checkOutput("rst_dstE", 64'(w_dst_e), 64'hF);
      checkOutput("rst_dstM", 64'(w_dst_m), 64'hF);
      checkOutput("rst_valE", w_val_e, 64'h0);
      checkOutput("rst_valM", w_val_m, 64'h0);
      checkOutput("rst_stat", 64'(prog_stat), 64'h1);
      checkOutput("rst_halted", 64'(halted), 64'h0);
      checkOutput("rst_nb_icode", 64'(nb_w_icode), 64'h1);
      checkOutput("rst_nb_dstE", 64'(nb_w_dst_e), 64'hF);
      checkOutput("rst_nb_dstM", 64'(nb_w_dst_m), 64'hF);
      checkOutput("rst_nb_valE", nb_w_val_e, 64'h0);
      checkOutput("rst_nb_valM", nb_w_val_m, 64'h0);
      checkOutput("rst_nb_stat", 64'(nb_prog_stat), 64'h1);
      checkOutput("rst_nb_halted", 64'(nb_halted), 64'h0);
      for (int i = 0; i < 15; i++) begin
         read_ports(4'(i), 4'(14 - i));
         checkOutput($sformatf("rst_sweepA_%0d", i), val_a, 64'h0);
         checkOutput($sformatf("rst_sweepB_%0d", i), val_b, 64'h0);
         checkOutput($sformatf("rst_nb_sweepB_%0d", i), nb_val_b, 64'h0);
      end

      for (int i = 0; i < 6; i++) begin
         applyStimulus(4'h1, vecs[i].icode, vecs[i].dst_e, vecs[i].dst_m,
                       vecs[i].val_e, vecs[i].val_m);
         step_cycle();
         apply_nop();
         read_ports(vecs[i].src_a, vecs[i].src_b);
         checkOutput($sformatf("vec%0d_bypassA", i), val_a, vecs[i].exp_byp_a);
         checkOutput($sformatf("vec%0d_nobypassA", i), nb_val_a, vecs[i].exp_nb_a);
         step_cycle();
         checkOutput($sformatf("vec%0d_valA", i), val_a, vecs[i].exp_a);
         checkOutput($sformatf("vec%0d_valB", i), val_b, vecs[i].exp_b);
         checkOutput($sformatf("vec%0d_nb_valA", i), nb_val_a, vecs[i].exp_a);
      end

      for (int i = 0; i < 15; i++) begin
         read_ports(4'(i), 4'(i));
         checkOutput($sformatf("sweep_%0d", i), val_a, sweep_exp[i]);
      end

      // Stall holds W for three cycles while new memory-stage values arrive.
      applyStimulus(4'h1, IIRMOVQ, 4'h3, RNONE, 64'h9, 64'h0);
      step_cycle();
      w_stall = 1'b1;
      applyStimulus(4'h1, IOPQ, 4'h5, 4'h6, 64'h77, 64'h88);
      for (int i = 0; i < 3; i++) begin
         step_cycle();
         checkOutput($sformatf("stall%0d_dstE", i), 64'(w_dst_e), 64'h3);
         checkOutput($sformatf("stall%0d_valE", i), w_val_e, 64'h9);
         checkOutput($sformatf("stall%0d_icode", i), 64'(w_icode), 64'(IIRMOVQ));
      end
      w_bubble = 1'b1;
      step_cycle();
      checkOutput("bubble_icode", 64'(w_icode), 64'h1);
      checkOutput("bubble_dstE", 64'(w_dst_e), 64'hF);
      checkOutput("bubble_valE", w_val_e, 64'h0);
      w_stall = 1'b0; w_bubble = 1'b0;
      apply_nop();
      step_cycle();
      read_ports(4'h3, 4'h5);
      checkOutput("bubble_reg3", val_a, 64'h9);
      checkOutput("bubble_reg5", val_b, 64'h0);

      // Halt: the instruction behind HLT must not commit.
      applyStimulus(4'h2, IHALT, RNONE, RNONE, 64'h0, 64'h0);
      step_cycle();
      applyStimulus(4'h1, IIRMOVQ, 4'h5, RNONE, 64'h7, 64'h0);
      step_cycle();
      checkOutput("halt_halted", 64'(halted), 64'h1);
      checkOutput("halt_stat", 64'(prog_stat), 64'h2);
      read_ports(4'h5, 4'h3);
      checkOutput("halt_no_bypass", val_a, 64'h0);
      applyStimulus(4'h1, IIRMOVQ, 4'h6, RNONE, 64'h1234, 64'h0);
      step_cycle();
      apply_nop();
      step_cycle();
      step_cycle();
      read_ports(4'h5, 4'h6);
      checkOutput("halt_reg5", val_a, 64'h0);
      checkOutput("halt_reg6", val_b, 64'h0);
      checkOutput("halt_sticky", 64'(halted), 64'h1);
      checkOutput("halt_stat_sticky", 64'(prog_stat), 64'h2);

      // Reset wins over stall while halted.
      applyStimulus(4'h1, IOPQ, 4'h6, RNONE, 64'h42, 64'h0);
      step_cycle();
      w_stall = 1'b1;
      reset = 1'b1;
      step_cycle();
      reset = 1'b0;
      w_stall = 1'b0;
      apply_nop();
      checkOutput("rst2_halted", 64'(halted), 64'h0);
      checkOutput("rst2_stat", 64'(prog_stat), 64'h1);
      checkOutput("rst2_icode", 64'(w_icode), 64'h1);
      checkOutput("rst2_dstE", 64'(w_dst_e), 64'hF);
      read_ports(4'h2, 4'h3);
      checkOutput("rst2_reg2", val_a, 64'h0);
      checkOutput("rst2_reg3", val_b, 64'h0);
      read_ports(4'hE, 4'h1);
      checkOutput("rst2_regE", val_a, 64'h0);
      checkOutput("rst2_reg1", val_b, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_wb.md
Name: regfile_wb

Overview:
- Writeback stage and register file for the Y86 pipeline. It sits at the far end of the register-ID interface that decode drives.
- Decode issues srcA/srcB read IDs and carries destE/destM forward. This block latches the memory-stage results into the W pipeline register, commits them to the 15-entry register file, and returns valA/valB to decode.
- It also tracks program status and stops all commits once a non-AOK status reaches W.

Parameters:
- WIDTH, 64, data width of registers and values.
- BYPASS, 1, when 1 a read of a register being written this cycle returns the W-stage value; when 0 it returns the stored value.

Ports:
- clock  in  1  system clock; rising-edge active.
- reset  in  1  synchronous, active-high.
- W_stall  in  1  hold the W pipeline register.
- W_bubble  in  1  load a nop bubble into the W pipeline register.
- m_stat  in  4  status from memory stage (AOK=1, HLT=2, ADR=3, INS=4).
- m_icode  in  4  instruction code from memory stage.
- m_valE  in  WIDTH  ALU result.
- m_valM  in  WIDTH  memory read result.
- m_dstE  in  4  register ID for valE (4'hF = RNONE).
- m_dstM  in  4  register ID for valM (4'hF = RNONE).
- srcA  in  4  read ID A from decode.
- srcB  in  4  read ID B from decode.
- valA  out  WIDTH  read data A.
- valB  out  WIDTH  read data B.
- W_icode  out  4  current W-stage icode.
- W_dstE  out  4  current W-stage dstE, for decode forwarding.
- W_dstM  out  4  current W-stage dstM, for decode forwarding.
- W_valE  out  WIDTH  current W-stage valE.
- W_valM  out  WIDTH  current W-stage valM.
- prog_stat  out  4  program status; BUBBLE status is reported as AOK.
- halted  out  1  sticky; set once a non-AOK status has reached W.

Behaviour:
- Reset, synchronous on the rising edge while reset=1:
  - W register takes the bubble values: icode=1 (nop), stat=AOK, dstE=dstM=F, valE=valM=0.
  - All 15 registers are cleared to 0; halted=0; prog_stat=AOK.
  - Reset overrides stall and bubble, including mid-program.
- W register update each rising edge:
  - reset=1: bubble values.
  - else W_bubble=1: bubble values (bubble wins over stall if both are asserted).
  - else W_stall=1: hold all fields.
  - else: load m_* inputs.
  - Latency from m_* to W_* outputs is one cycle.
- Register commit on each rising edge, using the current W contents before the W update:
  - Commit is enabled only when halted=0 and W_stat=AOK.
  - W_dstE != F: reg[W_dstE] <= W_valE.
  - W_dstM != F: reg[W_dstM] <= W_valM.
  - If W_dstE == W_dstM != F, W_valM wins.
  - ID F never stores anything.
- Status handling:
  - When W_stat is HLT, ADR or INS and halted=0: halted <= 1 on that edge, that instruction's writes are suppressed, and prog_stat <= W_stat.
  - Once halted=1, prog_stat and halted hold until reset, and no further commits occur regardless of W contents.
- Read paths are combinational from srcA/srcB.
  - ID F returns 0.
  - BYPASS=1, priority order: W_dstM match returns W_valM; else W_dstE match returns W_valE; else reg[id]. Bypass applies only when a commit is enabled this cycle.
  - BYPASS=0: always reg[id].
  - Any ID in 0..E with no match returns the stored value.
- No arithmetic is performed. Values pass through at full WIDTH with no truncation.

Decomposition:
- Shared package y86_pkg, holding:
  - icode constants (INOP=1, IHALT=0, IRRMOVQ=2, IIRMOVQ=3, IMRMOVQ=5, IOPQ=6, IPOPQ=B, ...);
  - RNONE=4'hF and the register IDs RRSP=4;
  - status codes SAOK=1, SHLT=2, SADR=3, SINS=4, SBUB=0.
- One sub-module, regfile15: 15 x WIDTH storage with two synchronous write ports (M-port priority on conflict) and two combinational read ports, F mapped to 0.
- regfile_wb wraps regfile15 with the W pipeline register, the bypass muxes and the status/halt logic.

Test Plan:
- Reset, then check defaults: apply reset 1 cycle → all regs read 0 via srcA/srcB sweep 0..E; W_icode=1, W_dstE=W_dstM=F, prog_stat=1, halted=0.
- Basic commit: m_dstE=2, m_valE=0x2A382812, m_stat=1; 2 edges → with srcA=2, valA=0x2A382812.
  - Same cycle-1 result with BYPASS=1: valA=0x2A382812 while W holds it.
  - Same cycle-1 result with BYPASS=0: valA=0 while W holds it.
- popq conflict: m_icode=B, m_dstE=4, m_valE=0x100, m_dstM=4, m_valM=0x55; commit → reg4=0x55.
  - Repeat with m_dstM=7 instead: reg4=0x100 and reg7=0x55.
- Stall and bubble:
  - W holds dstE=3/valE=9 with W_stall=1 for 3 cycles and new m_* applied → W_* unchanged.
  - Assert W_stall=1 and W_bubble=1 together → W_icode=1, dstE=F, reg3 unchanged by the bubble.
- Halt: W_stat=HLT with m_dstE=5, m_valE=7 behind it → halted=1, prog_stat=2, reg5 stays 0.
  - Later AOK writes are ignored until reset.
  - Reset mid-halt → halted=0 and regs cleared.
- RNONE reads and writes: srcA=F, srcB=F → valA=valB=0.
  - Write with dstE=F, valE=0xFFFF → no register changes (full sweep).
